// File: rtl/serial_sub.sv
// Bit-serial subtractor: x - y - bin computed LSB first, one full-subtractor step per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-2:0] r_sh;
  logic             br;

  logic             a;
  logic             b;
  logic             diff;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] r_next;

  assign a       = x_sh[0];
  assign b       = y_sh[0];
  assign diff    = a ^ b ^ br;
  assign br_next = (~a & b) | (~(a ^ b) & br);
  assign last    = (cnt == CW'(WIDTH - 1));
  // New difference bit enters from the MSB side; on the last step this is the full result.
  assign r_next  = {diff, r_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      x_sh <= '0;
      y_sh <= '0;
      r_sh <= '0;
      br   <= 1'b0;
      d    <= '0;
      bout <= 1'b0;
      done <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          x_sh <= x;
          y_sh <= y;
          br   <= bin;
          cnt  <= '0;
        end
      end else begin
        x_sh <= x_sh >> 1;
        y_sh <= y_sh >> 1;
        r_sh <= r_next[WIDTH-1:1];
        br   <= br_next;
        cnt  <= cnt + 1'b1;
        if (last) begin
          d    <= r_next;
          bout <= br_next;
          done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // br here is the borrow into the MSB, br_next the borrow out of it.
          ovf  <= br ^ br_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomised self-checking bench for serial_sub at WIDTH=8.
// Define SERIAL_SUB_OVF_EN for both files to exercise the ovf output as well.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       bout;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks;
  int failures;

  serial_sub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: start pulse, wait for done, check latency and result.
  task automatic run_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                        input logic bv, input logic [7:0] ed, input logic eb, input logic eo);
    int nb;
    int n;
    x = xv; y = yv; bin = bv; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    n  = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      tick();
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_cycles"}, nb, 8);
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_with_done"}, busy, 0);
    check({tag, "_d"}, d, ed);
    check({tag, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`endif
    $display("op %s: x=%02h y=%02h bin=%0d -> d=%02h bout=%0d (exp %02h %0d ovf %0d)",
             tag, xv, yv, bv, d, bout, ed, eb, eo);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] ry;
    logic       rb;
    logic [8:0] ex;
    logic       eo;
    int         n;
    int         ndone;
    int         sx;
    int         sy;
    int         sr;

    checks   = 0;
    failures = 0;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    tick();

    run_op("5m3",  8'd5, 8'd3, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("3m5",  8'd3, 8'd5, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("0m0b", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("80m1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("10m1", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Restart attempt while busy and operand change after capture must be ignored.
    x = 8'd9; y = 8'd4; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 3) start = 1'b1;
      if (n == 4) begin
        start = 1'b0;
        x = 8'hFF;
      end
    end while (!done && n < 20);
    check("restart_done", done, 1);
    check("restart_latency", n, 8);
    check("restart_d", d, 8'h05);
    check("restart_bout", bout, 0);
    $display("op restart: x=09 y=04 bin=0 -> d=%02h bout=%0d", d, bout);
    tick();
    tick();
    check("restart_no_second_busy", busy, 0);
    check("restart_no_second_done", done, 0);

    // Asynchronous reset in the middle of a run.
    x = 8'h20; y = 8'h01; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    check("abort_bout", bout, 0);
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    $display("op abort: reset mid-run, done count after release=%0d", ndone);
    run_op("after_rst", 8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0);

    // Full-rate back-to-back: start held high, new operands presented in each done cycle.
    for (int k = 0; k < 1000; k++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rb = 1'($urandom);
      ex = {1'b0, rx} - {1'b0, ry} - {8'd0, rb};
      sx = int'($signed(rx));
      sy = int'($signed(ry));
      sr = sx - sy - int'(rb);
      eo = (sr < -128) || (sr > 127);
      x = rx; y = ry; bin = rb; start = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!done && n < 20);
      check("b2b_done", done, 1);
      check("b2b_interval", n, 9);
      check("b2b_result", {bout, d}, ex);
`ifdef SERIAL_SUB_OVF_EN
      check("b2b_ovf", ovf, eo);
`endif
      $display("op b2b %0d: x=%02h y=%02h bin=%0d -> bout=%0d d=%02h exp=%03h ovf_exp=%0d",
               k, rx, ry, rb, bout, d, ex, eo);
      if (n >= 20) break;
    end
    start = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
